// File: rtl/stack_datapath_p.sv
// Gameplay datapath for the tower-stacking game: moves the active block with edge bounce,
// captures a drop, trims the block to its overlap with the one below, and tracks row/score/chances.
//   state    | meaning
//   S_IDLE   | waiting for start after reset
//   S_MOVE   | block slides one pixel per tick; drop captures position
//   S_CHECK  | overlap with the placed block is computed and registered
//   S_COMMIT | hit/miss applied, event strobe raised
//   S_OVER   | terminal (win or game over); only start or reset leaves
module stack_datapath_p #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int BLOCK_W0 = 32,
  parameter int ROW_H    = 4,
  parameter int Y_BASE   = 116,
  parameter int ROWS     = 16,
  parameter int CHANCES  = 10,
  parameter int SCORE_W  = 8,
  localparam int ROW_W   = $clog2(ROWS + 1),
  localparam int CH_W    = ($clog2(CHANCES + 1) > 4) ? $clog2(CHANCES + 1) : 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               tick,
  input  logic               drop,
  output logic [X_W-1:0]     cur_x,
  output logic [X_W-1:0]     cur_w,
  output logic [Y_W-1:0]     cur_y,
  output logic [X_W-1:0]     prev_x,
  output logic [X_W-1:0]     prev_w,
  output logic [ROW_W-1:0]   row,
  output logic [SCORE_W-1:0] score,
  output logic [CH_W-1:0]    chances,
  output logic               evt_valid,
  output logic               evt_hit,
  output logic               game_over,
  output logic               win
);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_CHECK, S_COMMIT, S_OVER} state_t;

  localparam logic [X_W:0]   SCREEN_L = (X_W + 1)'(SCREEN_W);
  localparam logic [X_W-1:0] BW0_L    = X_W'(BLOCK_W0);
  localparam logic [X_W-1:0] PX0_L    = X_W'((SCREEN_W - BLOCK_W0) / 2);
  localparam logic [Y_W-1:0] Y0_L     = Y_W'(Y_BASE);
  localparam logic [Y_W-1:0] RH_L     = Y_W'(ROW_H);
  localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);
  localparam logic [CH_W-1:0]  CH0_L  = CH_W'(CHANCES);

  state_t         r_state;
  logic           r_right;
  logic [X_W-1:0] r_lo;
  logic [X_W-1:0] r_ov;

  logic [X_W:0]     w_cur_end;
  logic [X_W:0]     w_prev_end;
  logic [X_W:0]     w_hi;
  logic [X_W-1:0]   w_lo;
  logic [X_W-1:0]   w_ov;
  logic [ROW_W-1:0] w_row_inc;

  // Overlap is evaluated one bit wider so right edges near the screen limit never wrap.
  assign w_cur_end  = {1'b0, cur_x} + {1'b0, cur_w};
  assign w_prev_end = {1'b0, prev_x} + {1'b0, prev_w};
  assign w_lo       = (cur_x >= prev_x) ? cur_x : prev_x;
  assign w_hi       = (w_cur_end <= w_prev_end) ? w_cur_end : w_prev_end;
  assign w_ov       = (w_hi > {1'b0, w_lo}) ? X_W'(w_hi - {1'b0, w_lo}) : '0;
  assign w_row_inc  = row + 1'b1;

  always_ff @(posedge clk) begin
    evt_valid <= 1'b0;
    evt_hit   <= 1'b0;
    if (!resetn || start) begin
      r_state   <= resetn ? S_MOVE : S_IDLE;
      r_right   <= 1'b1;
      r_lo      <= '0;
      r_ov      <= '0;
      cur_x     <= '0;
      cur_w     <= BW0_L;
      cur_y     <= Y0_L;
      prev_x    <= PX0_L;
      prev_w    <= BW0_L;
      row       <= '0;
      score     <= '0;
      chances   <= CH0_L;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      case (r_state)
        S_MOVE: begin
          if (drop) begin
            r_state <= S_CHECK;
          end else if (tick) begin
            if (r_right) begin
              if (w_cur_end >= SCREEN_L) begin
                r_right <= 1'b0;
                cur_x   <= cur_x - 1'b1;
              end else begin
                cur_x <= cur_x + 1'b1;
              end
            end else begin
              if (cur_x == '0) begin
                r_right <= 1'b1;
                cur_x   <= X_W'(1);
              end else begin
                cur_x <= cur_x - 1'b1;
              end
            end
          end
        end
        S_CHECK: begin
          r_lo    <= w_lo;
          r_ov    <= w_ov;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          cur_x     <= '0;
          r_right   <= 1'b1;
          evt_valid <= 1'b1;
          evt_hit   <= (r_ov != '0);
          if (r_ov != '0) begin
            prev_x <= r_lo;
            prev_w <= r_ov;
            cur_w  <= r_ov;
            cur_y  <= cur_y - RH_L;
            row    <= w_row_inc;
            if (score != '1) score <= score + 1'b1;
            if (w_row_inc == ROWS_L) begin
              win     <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_state <= S_MOVE;
            end
          end else begin
            if (chances != '0) chances <= chances - 1'b1;
            // New count is zero when one or fewer chances remained.
            if (chances <= CH_W'(1)) begin
              game_over <= 1'b1;
              r_state   <= S_OVER;
            end else begin
              r_state <= S_MOVE;
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_datapath_p.sv
// Directed and randomized checks of stack_datapath_p against a pixel-level game model.
module tb_stack_datapath_p;

  localparam int ROW_W = $clog2(17);
  localparam int CH_W  = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, tick = 1'b0, drop = 1'b0;
  logic [7:0] cur_x, cur_w, prev_x, prev_w;
  logic [6:0] cur_y;
  logic [ROW_W-1:0] row;
  logic [7:0] score;
  logic [CH_W-1:0] chances;
  logic evt_valid, evt_hit, game_over, win;

  logic start_b = 1'b0, tick_b = 1'b0, drop_b = 1'b0;
  logic [7:0] b_cur_x, b_cur_w, b_prev_x, b_prev_w;
  logic [6:0] b_cur_y;
  logic [1:0] b_row;
  logic [7:0] b_score;
  logic [CH_W-1:0] b_chances;
  logic b_evt_valid, b_evt_hit, b_game_over, b_win;

  int errs = 0;
  int checks = 0;

  // Reference game state
  int m_x, m_w, m_y, m_px, m_pw, m_row, m_score, m_ch, m_hit;
  bit m_right, m_move, m_go, m_win;

  always #5 clk = ~clk;

  stack_datapath_p dut (
    .clk(clk), .resetn(resetn), .start(start), .tick(tick), .drop(drop),
    .cur_x(cur_x), .cur_w(cur_w), .cur_y(cur_y), .prev_x(prev_x), .prev_w(prev_w),
    .row(row), .score(score), .chances(chances), .evt_valid(evt_valid),
    .evt_hit(evt_hit), .game_over(game_over), .win(win)
  );

  stack_datapath_p #(.ROWS(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .tick(tick_b), .drop(drop_b),
    .cur_x(b_cur_x), .cur_w(b_cur_w), .cur_y(b_cur_y), .prev_x(b_prev_x), .prev_w(b_prev_w),
    .row(b_row), .score(b_score), .chances(b_chances), .evt_valid(b_evt_valid),
    .evt_hit(b_evt_hit), .game_over(b_game_over), .win(b_win)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_init();
    m_x = 0; m_right = 1; m_w = 32; m_y = 116; m_px = 64; m_pw = 32;
    m_row = 0; m_score = 0; m_ch = 10; m_go = 0; m_win = 0;
  endtask

  task automatic m_tick();
    if (!m_move) return;
    if (m_right) begin
      if (m_x + m_w >= 160) begin m_right = 0; m_x = m_x - 1; end
      else m_x = m_x + 1;
    end else begin
      if (m_x == 0) begin m_right = 1; m_x = 1; end
      else m_x = m_x - 1;
    end
  endtask

  task automatic m_commit();
    int lo, hi;
    lo = (m_x > m_px) ? m_x : m_px;
    hi = (m_x + m_w < m_px + m_pw) ? m_x + m_w : m_px + m_pw;
    m_hit = (hi > lo) ? 1 : 0;
    if (m_hit == 1) begin
      m_px = lo; m_pw = hi - lo; m_w = hi - lo; m_y = m_y - 4;
      m_row++;
      if (m_score < 255) m_score++;
      if (m_row == 16) begin m_win = 1; m_move = 0; end
    end else begin
      if (m_ch > 0) m_ch--;
      if (m_ch == 0) begin m_go = 1; m_move = 0; end
    end
    m_x = 0; m_right = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cur_x"}, cur_x, m_x);
    chk({tag, ".cur_w"}, cur_w, m_w);
    chk({tag, ".cur_y"}, cur_y, m_y);
    chk({tag, ".prev_x"}, prev_x, m_px);
    chk({tag, ".prev_w"}, prev_w, m_pw);
    chk({tag, ".row"}, row, m_row);
    chk({tag, ".score"}, score, m_score);
    chk({tag, ".chances"}, chances, m_ch);
    chk({tag, ".game_over"}, game_over, m_go);
    chk({tag, ".win"}, win, m_win);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_init();
    m_move = 1;
    chk("start.evt_valid", evt_valid, 0);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      m_tick();
    end
    tick = 1'b0;
  endtask

  task automatic do_drop(input string tag, input bit with_tick);
    bit was_move;
    was_move = m_move;
    drop = 1'b1;
    tick = with_tick;
    @(negedge clk);
    drop = 1'b0;
    tick = 1'b0;
    if (with_tick) chk({tag, ".frozen_x"}, cur_x, m_x);
    @(negedge clk);
    chk({tag, ".no_early_evt"}, evt_valid, 0);
    @(negedge clk);
    if (was_move) begin
      m_commit();
      chk({tag, ".evt_valid"}, evt_valid, 1);
      chk({tag, ".evt_hit"}, evt_hit, m_hit);
    end else begin
      chk({tag, ".evt_idle"}, evt_valid, 0);
    end
    check_all(tag);
    @(negedge clk);
    chk({tag, ".evt_one_cycle"}, evt_valid, 0);
  endtask

  task automatic b_drop_after(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick_b = 1'b1;
      @(negedge clk);
    end
    tick_b = 1'b0;
    drop_b = 1'b1;
    @(negedge clk);
    drop_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".evt_valid"}, b_evt_valid, 1);
    chk({tag, ".evt_hit"}, b_evt_hit, 1);
    chk({tag, ".prev_x"}, b_prev_x, 64);
    chk({tag, ".prev_w"}, b_prev_w, 32);
  endtask

  initial begin
    m_init();
    m_move = 0;
    repeat (2) @(negedge clk);
    chk("reset.evt_valid", evt_valid, 0);
    chk("reset.evt_hit", evt_hit, 0);
    check_all("reset");
    resetn = 1'b1;
    do_ticks(3);
    chk("idle.tick_ignored", cur_x, 0);
    do_drop("idle_drop", 0);

    // Miss at x=10
    do_start();
    do_ticks(10);
    chk("miss.x_before", cur_x, 10);
    do_drop("miss", 0);
    chk("miss.chances", chances, 9);
    chk("miss.hit", m_hit, 0);

    // Trim at x=70
    do_start();
    do_ticks(70);
    do_drop("trim", 0);
    chk("trim.prev_x", prev_x, 70);
    chk("trim.prev_w", prev_w, 26);
    chk("trim.cur_y", cur_y, 112);

    // Bounce at both edges
    do_start();
    do_ticks(128);
    chk("bounce.128", cur_x, 128);
    do_ticks(1);
    chk("bounce.129", cur_x, 127);
    do_ticks(127);
    chk("bounce.256", cur_x, 0);
    do_ticks(1);
    chk("bounce.257", cur_x, 1);

    // Exhaust all chances
    do_start();
    for (int i = 0; i < 10; i++) do_drop("exhaust", 0);
    chk("exhaust.game_over", game_over, 1);
    chk("exhaust.chances", chances, 0);
    do_drop("over_drop", 0);
    do_ticks(4);
    chk("over.tick_ignored", cur_x, 0);
    do_start();
    check_all("restart");

    // Tick and drop together
    do_start();
    do_ticks(5);
    do_drop("prio", 1);

    // Reset while COMMIT is pending
    do_start();
    do_ticks(70);
    drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_init();
    m_move = 0;
    chk("rst_commit.evt_valid", evt_valid, 0);
    check_all("rst_commit");
    @(negedge clk);
    chk("rst_commit.evt_after", evt_valid, 0);
    do_ticks(2);
    chk("rst_commit.idle", cur_x, 0);

    // Randomized play against the model
    do_start();
    for (int n = 0; n < 40; n++) begin
      if (!m_move) do_start();
      do_ticks($urandom_range(0, 300));
      check_all("rand_move");
      do_drop("rand_drop", ($urandom_range(0, 3) == 0));
    end

    // Two-row win on the small instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    b_drop_after(64, "win1");
    chk("win1.win", b_win, 0);
    b_drop_after(64, "win2");
    chk("win.row", b_row, 2);
    chk("win.score", b_score, 2);
    chk("win.flag", b_win, 1);
    chk("win.game_over", b_game_over, 0);
    chk("win.cur_y", b_cur_y, 108);
    for (int i = 0; i < 5; i++) begin
      tick_b = 1'b1;
      @(negedge clk);
    end
    tick_b = 1'b0;
    chk("win.tick_ignored", b_cur_x, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
